// File: rtl/signed_stream_accumulator_if.sv
// Operand and result stream bundle for signed_stream_accumulator.
// master drives operands and result-ready; slave is the accumulator.
interface signed_stream_accumulator_if #(
  parameter int WIDTH = 8
);
  logic             up_valid;
  logic [WIDTH-1:0] up_data;
  logic             up_ready;
  logic             down_valid;
  logic [WIDTH-1:0] down_sum;
  logic             down_overflow;
  logic             down_ready;

  modport master (
    output up_valid,
    output up_data,
    output down_ready,
    input  up_ready,
    input  down_valid,
    input  down_sum,
    input  down_overflow
  );

  modport slave (
    input  up_valid,
    input  up_data,
    input  down_ready,
    output up_ready,
    output down_valid,
    output down_sum,
    output down_overflow
  );
endinterface

// File: rtl/signed_stream_accumulator.sv
// Signed batch accumulator: sums COUNT operands, sticky overflow flag.
// SIGNED_STREAM_ACCUMULATOR_SATURATE_EN: clamp on overflow, else wrap.
module signed_stream_accumulator #(
  parameter int WIDTH = 8,
  parameter int COUNT = 4
) (
  input logic clk,
  input logic rst_n,
  signed_stream_accumulator_if.slave bus
);
  localparam int CW = $clog2(COUNT + 1);
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [WIDTH-1:0] SMAX =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN =
    {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {
    ACCUM,
    HOLD
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] nxt;
  logic             ovf_q;
  logic             ovf_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             step_ovf;
  logic             same_sign;
  logic             up_fire;
  logic             down_fire;

  assign nxt = acc_q + bus.up_data;

  // Overflow only when both addends agree in sign and the sum does not.
  assign same_sign =
    acc_q[WIDTH-1] == bus.up_data[WIDTH-1];
  assign step_ovf =
    same_sign && (nxt[WIDTH-1] != acc_q[WIDTH-1]);

  assign up_fire = bus.up_valid && (state_q == ACCUM);
  assign down_fire = bus.down_ready && (state_q == HOLD);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      up_fire: begin
        ovf_d = ovf_q | step_ovf;
`ifdef SIGNED_STREAM_ACCUMULATOR_SATURATE_EN
        if (step_ovf) begin
          acc_d = acc_q[WIDTH-1] ? SMIN : SMAX;
        end else begin
          acc_d = nxt;
        end
`else
        acc_d = nxt;
`endif
        if (cnt_q == LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      down_fire: begin
        state_d = ACCUM;
        acc_d   = '0;
        ovf_d   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.up_ready      = (state_q == ACCUM);
  assign bus.down_valid    = (state_q == HOLD);
  assign bus.down_sum      = acc_q;
  assign bus.down_overflow = ovf_q;
endmodule

// File: tb/tb_signed_stream_accumulator.sv
// Bench for signed_stream_accumulator (WIDTH=4, COUNT=4): directed
// scenarios then random traffic against a batch-level arithmetic model.
module tb_signed_stream_accumulator;
  localparam int W = 4;
  localparam int N = 4;
  localparam int MAXV = 2 ** (W - 1) - 1;
  localparam int MINV = -(2 ** (W - 1));
  localparam int SPAN = 2 ** W;

  logic clk;
  logic rst_n;
  int vectors;
  int miscompares;
  int q[$];
  bit m_hold;

  signed_stream_accumulator_if #(.WIDTH(W)) bus ();

  signed_stream_accumulator #(
    .WIDTH(W),
    .COUNT(N)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Fold accepted operands with integer arithmetic and range tests.
  function automatic void fold(output logic [W-1:0] s,
                               output logic o);
    int a;
    int t;
    a = 0;
    o = 1'b0;
    foreach (q[i]) begin
      t = a + q[i];
      if (t > MAXV || t < MINV) begin
        o = 1'b1;
`ifdef SIGNED_STREAM_ACCUMULATOR_SATURATE_EN
        a = (t > MAXV) ? MAXV : MINV;
`else
        a = (t > MAXV) ? t - SPAN : t + SPAN;
`endif
      end else begin
        a = t;
      end
    end
    s = a[W-1:0];
  endfunction

  task automatic cycle(input bit uv,
                       input logic [W-1:0] ud,
                       input bit dr);
    logic [W-1:0] es;
    logic eo;
    @(negedge clk);
    fold(es, eo);
    check("up_ready", 32'(bus.up_ready), 32'(!m_hold));
    check("down_valid", 32'(bus.down_valid), 32'(m_hold));
    check("down_sum", 32'(bus.down_sum), 32'(es));
    check("down_overflow", 32'(bus.down_overflow), 32'(eo));
    bus.up_valid   = uv;
    bus.up_data    = ud;
    bus.down_ready = dr;
    if (!m_hold && uv) begin
      q.push_back(int'($signed(ud)));
      if (q.size() == N) m_hold = 1'b1;
    end else if (m_hold && dr) begin
      q.delete();
      m_hold = 1'b0;
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    m_hold = 1'b0;
    rst_n = 1'b0;
    bus.up_valid = 1'b0;
    bus.up_data = '0;
    bus.down_ready = 1'b0;

    cycle(0, 4'h0, 1);
    rst_n = 1'b1;

    // plain sum 3,2,1,1
    cycle(1, 4'd3, 1);
    cycle(1, 4'd2, 1);
    cycle(1, 4'd1, 1);
    cycle(1, 4'd1, 1);
    cycle(0, 4'h0, 1);
    check("plain_valid", 32'(bus.down_valid), 32'd1);
    check("plain_sum", 32'(bus.down_sum), 32'd7);
    check("plain_ovf", 32'(bus.down_overflow), 32'd0);
    cycle(0, 4'h0, 1);
    check("plain_ready_after", 32'(bus.up_ready), 32'd1);

    // positive overflow 7,1,0,0
    cycle(1, 4'd7, 1);
    cycle(1, 4'd1, 1);
    cycle(1, 4'd0, 1);
    cycle(1, 4'd0, 1);
    cycle(0, 4'h0, 1);
`ifdef SIGNED_STREAM_ACCUMULATOR_SATURATE_EN
    check("pos_sum", 32'(bus.down_sum), 32'h7);
`else
    check("pos_sum", 32'(bus.down_sum), 32'h8);
`endif
    check("pos_ovf", 32'(bus.down_overflow), 32'd1);

    // negative overflow -8,-1,1,0 with sticky flag
    cycle(1, 4'h8, 1);
    cycle(1, 4'hf, 1);
    cycle(1, 4'h1, 1);
    cycle(1, 4'h0, 1);
    cycle(0, 4'h0, 1);
`ifdef SIGNED_STREAM_ACCUMULATOR_SATURATE_EN
    check("neg_sum", 32'(bus.down_sum), 32'h9);
`else
    check("neg_sum", 32'(bus.down_sum), 32'h8);
`endif
    check("neg_ovf", 32'(bus.down_overflow), 32'd1);

    // backpressure while producer keeps offering 5
    cycle(1, 4'd1, 0);
    cycle(1, 4'd1, 0);
    cycle(1, 4'd1, 0);
    cycle(1, 4'd1, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 4'd5, 0);
      check("bp_sum", 32'(bus.down_sum), 32'd4);
      check("bp_ovf", 32'(bus.down_overflow), 32'd0);
      check("bp_up_ready", 32'(bus.up_ready), 32'd0);
    end
    cycle(1, 4'd5, 1);
    cycle(1, 4'd5, 1);
    cycle(1, 4'd0, 1);
    cycle(1, 4'd0, 1);
    cycle(1, 4'd0, 1);
    cycle(0, 4'h0, 1);
    check("bp_next_sum", 32'(bus.down_sum), 32'd5);

    // stalls between operands, junk data while idle
    cycle(1, 4'd1, 1);
    cycle(0, 4'd9, 1);
    cycle(1, 4'd2, 1);
    cycle(0, 4'h0, 1);
    cycle(0, 4'd3, 1);
    cycle(1, 4'd3, 1);
    cycle(0, 4'hf, 1);
    cycle(1, 4'd1, 1);
    cycle(0, 4'h0, 1);
    check("stall_sum", 32'(bus.down_sum), 32'd7);
    check("stall_ovf", 32'(bus.down_overflow), 32'd0);

    // reset after two operands
    cycle(0, 4'h0, 1);
    cycle(1, 4'd7, 1);
    cycle(1, 4'd7, 1);
    @(negedge clk);
    bus.up_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_up_ready", 32'(bus.up_ready), 32'd1);
    check("rst_down_valid", 32'(bus.down_valid), 32'd0);
    check("rst_sum", 32'(bus.down_sum), 32'd0);
    check("rst_ovf", 32'(bus.down_overflow), 32'd0);
    q.delete();
    m_hold = 1'b0;
    cycle(0, 4'h0, 1);
    rst_n = 1'b1;
    cycle(1, 4'd1, 1);
    cycle(1, 4'd1, 1);
    cycle(1, 4'd1, 1);
    cycle(1, 4'd1, 1);
    cycle(0, 4'h0, 1);
    check("fresh_sum", 32'(bus.down_sum), 32'd4);
    check("fresh_ovf", 32'(bus.down_overflow), 32'd0);

    // random traffic with stalls on both sides
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0,
            W'($urandom),
            $urandom_range(0, 2) != 0);
    end
    cycle(0, 4'h0, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/signed_stream_accumulator.md
# signed_stream_accumulator

Parametrised signed (two's complement) accumulator that sums a fixed-length batch of `COUNT` operands arriving over a valid/ready stream. It reports the `WIDTH`-bit batch sum together with a sticky overflow flag. It is the sequential, width-generic successor of the 4-bit signed adder with overflow detection. It sits between an operand producer and a result consumer, and both sides may stall.

## Interface
- `WIDTH`, 8: operand and sum width in bits, ≥ 2.
- `COUNT`, 4: operands per batch, ≥ 1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `up_valid`  in  1  operand present on `up_data`.
- `up_data`  in  WIDTH  signed operand.
- `up_ready`  out  1  accumulator accepts an operand this cycle.
- `down_valid`  out  1  batch result present.
- `down_sum`  out  WIDTH  signed batch sum.
- `down_overflow`  out  1  at least one step of this batch overflowed.
- `down_ready`  in  1  consumer accepts the result this cycle.

## Operation
- Two states:
  - ACCUM: `up_ready`=1, `down_valid`=0.
  - HOLD: `up_ready`=0, `down_valid`=1.
- Operand transfer: `up_valid & up_ready` on a clock edge.
- Result transfer: `down_valid & down_ready` on a clock edge.
- Registers:
  - `acc` (WIDTH).
  - `ovf` (1, sticky).
  - operand counter `cnt`, width `$clog2(COUNT+1)`.
- Each operand transfer:
  - `nxt = acc + up_data`, truncated to WIDTH.
  - Step overflow: `a[W-1]==b[W-1]` and `nxt[W-1]!=a[W-1]`, where a=`acc` and b=`up_data`.
  - Update: `acc <= nxt` (see Configuration), `ovf <= ovf | step_ovf`, `cnt <= cnt+1`.
- On the transfer where `cnt == COUNT-1`:
  - go to HOLD;
  - `acc` and `ovf` then hold the final result; `cnt` clears to 0.
- `down_sum` = `acc`; `down_overflow` = `ovf`. Both are driven directly from registers.
- HOLD with `down_ready`=1: go to ACCUM and clear `acc` and `ovf` to 0 on the same edge.
- HOLD with `down_ready`=0: `acc`, `ovf` and state all hold. Outputs stay stable until accepted.
- `up_valid` during HOLD is ignored; nothing is consumed.
- `up_data` is ignored whenever `up_valid`=0.
- `COUNT`=1: every accepted operand moves directly to HOLD. The result is that operand, with `ovf`=0.
- Reset (any time, including mid-batch or in HOLD):
  - state ACCUM, `acc`=0, `ovf`=0, `cnt`=0;
  - any partial batch is discarded.
- Outputs during reset: `up_ready`=1, `down_valid`=0, `down_sum`=0, `down_overflow`=0.

## Timing
- One operand per cycle while in ACCUM; no bubbles within a batch.
- Latency: last operand accepted at edge t gives `down_valid`=1 in the cycle after t.
- Throughput: `COUNT` operand cycles plus ≥ 1 HOLD cycle per batch. The next batch's first operand can be accepted at the earliest one cycle after the result transfer.
- `up_ready` and `down_valid` are registered-state decodes and do not depend combinationally on `up_valid` or `down_ready`.

## Configuration
- `SIGNED_STREAM_ACCUMULATOR_SATURATE_EN`
  - Defined: on `step_ovf` the accumulator clamps instead of wrapping.
    - Positive overflow loads `2^(W-1)-1`.
    - Negative overflow loads `-2^(W-1)`.
    - Later operands add to the clamped value.
  - Undefined: `acc` takes the truncated, wrapped `nxt`.
  - `ovf` behaviour is identical in both builds.

## Test plan
All scenarios use WIDTH=4, COUNT=4.
- Plain sum: operands 3, 2, 1, 1 back-to-back, `down_ready`=1 → one cycle after the 4th transfer `down_valid`=1, `down_sum`=7, `down_overflow`=0; next cycle `up_ready`=1.
- Positive overflow: operands 7, 1, 0, 0 →
  - wrap build: `down_sum`=-8 (4'b1000), `down_overflow`=1;
  - saturate build: `down_sum`=7, `down_overflow`=1.
- Negative overflow and sticky flag: operands -8, -1, 1, 0 →
  - wrap build: `down_sum`=-8, `down_overflow`=1 (the flag stays set although the last steps are clean);
  - saturate build: `down_sum`=-7, `down_overflow`=1.
- Backpressure: complete a batch with `down_ready`=0 for 3 cycles, while `up_valid`=1 with `up_data`=5 →
  - `down_sum` and `down_overflow` are stable and `up_ready`=0 throughout;
  - after `down_ready`=1 the next batch starts from 0, and operands 5, 0, 0, 0 give `down_sum`=5.
- Stall within batch: `up_valid` gaps between operands 1, 2, 3, 1 → result 7, `down_overflow`=0; the gaps do not advance `cnt`.
- Reset mid-operation: assert `rst_n`=0 after 2 of 4 operands (7, 7) →
  - outputs immediately `up_ready`=1, `down_valid`=0, `down_sum`=0, `down_overflow`=0;
  - after release, a fresh batch 1, 1, 1, 1 gives `down_sum`=4, `down_overflow`=0.
